// File: rtl/bp_train_sched_pkg.sv
// rtl/bp_train_sched_pkg.sv - shared types, counter layout and saturating helpers for predictor training
package bp_train_sched_pkg;

    localparam int BP_CTR_W = 2;
    localparam int LOC_LSB  = 0;
    localparam int GLB_LSB  = BP_CTR_W;
    localparam int CHS_LSB  = 2 * BP_CTR_W;
    localparam int TBL_W    = 3 * BP_CTR_W;

    typedef logic [BP_CTR_W-1:0] ctr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } train_st_e;

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == {BP_CTR_W{1'b1}}) ? c : c + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

endpackage

// File: rtl/bp_train_sched_fifo.sv
// rtl/bp_train_sched_fifo.sv - parameterised sync FIFO holding resolved branches awaiting training
module bp_train_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [W-1:0]  wdata_i,
    input  logic          pop_i,
    output logic [W-1:0]  rdata_o,
    output logic [AW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        push_ok  = push_i & ~full_o;
        pop_ok   = pop_i & ~empty_o;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leaves the occupancy unchanged.
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bp_train_sched.sv
// rtl/bp_train_sched.sv - arbitrates the shared predictor table port and trains counters by read-modify-write
module bp_train_sched
    import bp_train_sched_pkg::*;
#(
    parameter int IDX_W      = 8,
    parameter int Q_DEPTH    = 4,
    parameter int STARVE_LIM = 8,
    parameter int PC_WIDTH   = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                D_br_valid_i,
    input  logic [PC_WIDTH-1:0] D_br_pc_i,
    input  logic                D_br_taken_i,
    input  logic                D_local_hit_i,
    input  logic                D_global_hit_i,
    output logic                D_br_ready_o,
    input  logic                F_lookup_i,
    input  logic [PC_WIDTH-1:0] F_lookup_pc_i,
    output logic                F_stall_o,
    output logic [IDX_W-1:0]    ghr_o,
    output logic                tbl_en_o,
    output logic                tbl_we_o,
    output logic [IDX_W-1:0]    tbl_lidx_o,
    output logic [IDX_W-1:0]    tbl_gidx_o,
    output logic [TBL_W-1:0]    tbl_wdata_o,
    input  logic [TBL_W-1:0]    tbl_rdata_i
);

    localparam int ENT_W = IDX_W + 3;
    localparam int QA_W  = $clog2(Q_DEPTH);
    localparam int SC_W  = $clog2(STARVE_LIM + 1);
    localparam logic [QA_W:0] CNT_ONE = 1;

    train_st_e          state_q, state_d;
    logic [SC_W-1:0]    starve_q, starve_d;
    logic [IDX_W-1:0]   ghr_q, ghr_d;
    logic [TBL_W-1:0]   rd_q, rd_d;
    logic               cap_q, cap_d;
    logic [IDX_W-1:0]   lidx_q, lidx_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;

    logic               push_en, pop_en;
    logic [ENT_W-1:0]   head;
    logic [QA_W:0]      q_count;
    logic               q_full, q_empty;
    logic [IDX_W-1:0]   head_idx;
    logic               head_taken, head_lh, head_gh;
    logic               train_active, force_train, fetch_grant, train_grant;
    logic [IDX_W-1:0]   fetch_idx;
    logic [TBL_W-1:0]   rd_eff, wdata;
    ctr_t               loc_n, glb_n, chs_n;
    logic               unused_pc_bits;

    assign unused_pc_bits = ^{D_br_pc_i[PC_WIDTH-1:IDX_W+2], D_br_pc_i[1:0],
                              F_lookup_pc_i[PC_WIDTH-1:IDX_W+2], F_lookup_pc_i[1:0]};

    assign push_en      = D_br_valid_i & ~q_full;
    assign D_br_ready_o = ~q_full;
    assign ghr_o        = ghr_q;

    bp_train_fifo #(
        .W     (ENT_W),
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_en),
        .wdata_i ({D_br_pc_i[IDX_W+1:2], D_br_taken_i, D_local_hit_i, D_global_hit_i}),
        .pop_i   (pop_en),
        .rdata_o (head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign head_idx   = head[ENT_W-1:3];
    assign head_taken = head[2];
    assign head_lh    = head[1];
    assign head_gh    = head[0];

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        ghr_d       = ghr_q;
        rd_d        = rd_q;
        cap_d       = cap_q;
        lidx_d      = lidx_q;
        gidx_d      = gidx_q;
        pop_en      = 1'b0;
        tbl_en_o    = 1'b0;
        tbl_we_o    = 1'b0;
        tbl_lidx_o  = '0;
        tbl_gidx_o  = '0;
        tbl_wdata_o = '0;

        train_active = (state_q != ST_IDLE);
        force_train  = train_active && (starve_q == SC_W'(STARVE_LIM));
        fetch_grant  = F_lookup_i && !force_train;
        train_grant  = train_active && !fetch_grant;
        F_stall_o    = force_train;
        fetch_idx    = F_lookup_pc_i[IDX_W+1:2];

        // First WR cycle sees the read data live; later cycles use the captured copy.
        rd_eff = cap_q ? tbl_rdata_i : rd_q;
        loc_n  = head_taken ? sat_inc(rd_eff[LOC_LSB +: BP_CTR_W]) : sat_dec(rd_eff[LOC_LSB +: BP_CTR_W]);
        glb_n  = head_taken ? sat_inc(rd_eff[GLB_LSB +: BP_CTR_W]) : sat_dec(rd_eff[GLB_LSB +: BP_CTR_W]);
        chs_n  = rd_eff[CHS_LSB +: BP_CTR_W];
        if (head_gh && !head_lh) begin
            chs_n = sat_inc(chs_n);
        end else if (head_lh && !head_gh) begin
            chs_n = sat_dec(chs_n);
        end
        wdata = {chs_n, glb_n, loc_n};

        if (fetch_grant) begin
            tbl_en_o   = 1'b1;
            tbl_lidx_o = fetch_idx;
            tbl_gidx_o = fetch_idx ^ ghr_q;
        end

        if (!train_active || train_grant) begin
            starve_d = '0;
        end else if (fetch_grant && (starve_q != SC_W'(STARVE_LIM))) begin
            starve_d = starve_q + SC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                if (train_grant) begin
                    tbl_en_o   = 1'b1;
                    tbl_lidx_o = head_idx;
                    tbl_gidx_o = head_idx ^ ghr_q;
                    lidx_d     = head_idx;
                    gidx_d     = head_idx ^ ghr_q;
                    cap_d      = 1'b1;
                    state_d    = ST_WR;
                end
            end
            ST_WR: begin
                if (cap_q) begin
                    rd_d  = tbl_rdata_i;
                    cap_d = 1'b0;
                end
                if (train_grant) begin
                    tbl_en_o    = 1'b1;
                    tbl_we_o    = 1'b1;
                    tbl_lidx_o  = lidx_q;
                    tbl_gidx_o  = gidx_q;
                    tbl_wdata_o = wdata;
                    pop_en      = 1'b1;
                    ghr_d       = {ghr_q[IDX_W-2:0], head_taken};
                    state_d     = ((q_count > CNT_ONE) || push_en) ? ST_RD : ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            starve_q <= '0;
            ghr_q    <= '0;
            rd_q     <= '0;
            cap_q    <= 1'b0;
            lidx_q   <= '0;
            gidx_q   <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            ghr_q    <= ghr_d;
            rd_q     <= rd_d;
            cap_q    <= cap_d;
            lidx_q   <= lidx_d;
            gidx_q   <= gidx_d;
        end
    end

endmodule

// File: tb/tb_bp_train_sched.sv
// tb/tb_bp_train_sched.sv - scoreboard bench for bp_train_sched with directed branch vectors
module tb_bp_train_sched;

    logic        clk;
    logic        rst_n;
    logic        D_br_valid_i;
    logic [31:0] D_br_pc_i;
    logic        D_br_taken_i;
    logic        D_local_hit_i;
    logic        D_global_hit_i;
    logic        D_br_ready_o;
    logic        F_lookup_i;
    logic [31:0] F_lookup_pc_i;
    logic        F_stall_o;
    logic [7:0]  ghr_o;
    logic        tbl_en_o;
    logic        tbl_we_o;
    logic [7:0]  tbl_lidx_o;
    logic [7:0]  tbl_gidx_o;
    logic [5:0]  tbl_wdata_o;
    logic [5:0]  tbl_rdata_i;

    bp_train_sched #(
        .IDX_W      (8),
        .Q_DEPTH    (4),
        .STARVE_LIM (8),
        .PC_WIDTH   (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .D_br_valid_i   (D_br_valid_i),
        .D_br_pc_i      (D_br_pc_i),
        .D_br_taken_i   (D_br_taken_i),
        .D_local_hit_i  (D_local_hit_i),
        .D_global_hit_i (D_global_hit_i),
        .D_br_ready_o   (D_br_ready_o),
        .F_lookup_i     (F_lookup_i),
        .F_lookup_pc_i  (F_lookup_pc_i),
        .F_stall_o      (F_stall_o),
        .ghr_o          (ghr_o),
        .tbl_en_o       (tbl_en_o),
        .tbl_we_o       (tbl_we_o),
        .tbl_lidx_o     (tbl_lidx_o),
        .tbl_gidx_o     (tbl_gidx_o),
        .tbl_wdata_o    (tbl_wdata_o),
        .tbl_rdata_i    (tbl_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] lidx;
        logic [7:0] gidx;
        logic [5:0] w;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    int         stall_seen = 0;
    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] ghr_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (F_stall_o) stall_seen++;
        if (rst_n && tbl_en_o && tbl_we_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got lidx 0x%0h wdata 0x%0h expected no write", tbl_lidx_o, tbl_wdata_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_lidx", {24'd0, tbl_lidx_o}, {24'd0, mon_e.lidx});
                chk("wr_gidx", {24'd0, tbl_gidx_o}, {24'd0, mon_e.gidx});
                chk("wr_wdata", {26'd0, tbl_wdata_o}, {26'd0, mon_e.w});
            end
        end
    end

    function automatic logic [5:0] exp_w(input logic [5:0] r, input logic t, input logic lh, input logic gh);
        logic [1:0] l, g, c;
        l = r[1:0];
        g = r[3:2];
        c = r[5:4];
        if (t) begin
            if (l != 2'd3) l = l + 2'd1;
            if (g != 2'd3) g = g + 2'd1;
        end else begin
            if (l != 2'd0) l = l - 2'd1;
            if (g != 2'd0) g = g - 2'd1;
        end
        if (gh && !lh && c != 2'd3) c = c + 2'd1;
        if (lh && !gh && c != 2'd0) c = c - 2'd1;
        return {c, g, l};
    endfunction

    task automatic enq(input logic [31:0] pc, input logic t, input logic lh, input logic gh,
                       input logic [5:0] w, input logic track);
        wr_t e;
        D_br_valid_i   = 1'b1;
        D_br_pc_i      = pc;
        D_br_taken_i   = t;
        D_local_hit_i  = lh;
        D_global_hit_i = gh;
        if (track) begin
            e.lidx = pc[9:2];
            e.gidx = pc[9:2] ^ ghr_m;
            e.w    = w;
            exp_q.push_back(e);
            ghr_m = {ghr_m[6:0], t};
        end
        @(posedge clk);
        #1;
        D_br_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int s0, n, n_en;
        rst_n          = 1'b0;
        D_br_valid_i   = 1'b0;
        D_br_pc_i      = '0;
        D_br_taken_i   = 1'b0;
        D_local_hit_i  = 1'b0;
        D_global_hit_i = 1'b0;
        F_lookup_i     = 1'b0;
        F_lookup_pc_i  = '0;
        tbl_rdata_i    = '0;
        ghr_m          = '0;
        #1;
        chk("rst_ready", D_br_ready_o, 1);
        chk("rst_stall", F_stall_o, 0);
        chk("rst_ghr", ghr_o, 0);
        chk("rst_en_we", {tbl_en_o, tbl_we_o}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single taken branch, local right / global wrong; write lands three cycles after enqueue.
        tbl_rdata_i = 6'b01_01_01;
        enq(32'h100, 1'b1, 1'b1, 1'b0, 6'b00_10_10, 1'b1);
        @(negedge clk) chk("lat_idle", tbl_en_o, 0);
        @(negedge clk) chk("lat_rd", {tbl_en_o, tbl_we_o}, 2'b10);
        @(negedge clk) chk("lat_wr", {tbl_en_o, tbl_we_o}, 2'b11);
        @(posedge clk);
        #1 chk("ghr_a", ghr_o, 8'h01);

        enq(32'h100, 1'b1, 1'b0, 1'b1, 6'b10_10_10, 1'b1);
        wait_drain(20, "drain_b");
        chk("ghr_b", ghr_o, 8'h03);

        tbl_rdata_i = 6'b11_11_00;
        enq(32'h100, 1'b1, 1'b1, 1'b1, 6'b11_11_01, 1'b1);
        wait_drain(20, "drain_sat_up");
        chk("ghr_c", ghr_o, 8'h07);

        tbl_rdata_i = 6'b00_00_00;
        enq(32'h104, 1'b0, 1'b0, 1'b0, 6'b00_00_00, 1'b1);
        wait_drain(20, "drain_sat_dn");
        chk("ghr_d", ghr_o, 8'h0E);

        // Fill the queue under continuous fetch pressure; training only advances via starvation override.
        tbl_rdata_i   = 6'b10_01_10;
        F_lookup_i    = 1'b1;
        F_lookup_pc_i = 32'h0000_1000;
        s0 = stall_seen;
        chk("fill_rdy0", D_br_ready_o, 1);
        enq(32'h200, 1'b1, 1'b1, 1'b0, exp_w(6'b10_01_10, 1'b1, 1'b1, 1'b0), 1'b1);
        chk("fill_rdy1", D_br_ready_o, 1);
        enq(32'h3FC, 1'b0, 1'b0, 1'b1, exp_w(6'b10_01_10, 1'b0, 1'b0, 1'b1), 1'b1);
        chk("fill_rdy2", D_br_ready_o, 1);
        enq(32'h008, 1'b1, 1'b1, 1'b1, exp_w(6'b10_01_10, 1'b1, 1'b1, 1'b1), 1'b1);
        chk("fill_rdy3", D_br_ready_o, 1);
        enq(32'h154, 1'b1, 1'b0, 1'b0, exp_w(6'b10_01_10, 1'b1, 1'b0, 1'b0), 1'b1);
        chk("full_rdy", D_br_ready_o, 0);

        // Offer an extra branch across the first pop; it must be refused.
        D_br_valid_i = 1'b1;
        D_br_pc_i    = 32'h0F0;
        D_br_taken_i = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(tbl_en_o && tbl_we_o) && n < 100);
        chk("pop_seen", tbl_we_o, 1);
        chk("pop_rdy", D_br_ready_o, 0);
        @(posedge clk);
        #1 D_br_valid_i = 1'b0;
        chk("after_pop_rdy", D_br_ready_o, 1);
        wait_drain(200, "fill_drain");
        chk("stall_pulses", stall_seen - s0, 8);
        chk("ghr_fill", ghr_o, ghr_m);
        F_lookup_i = 1'b0;

        // Fetch takes the port during WR for three cycles; captured read data must survive.
        tbl_rdata_i = 6'b01_10_11;
        enq(32'h2A4, 1'b0, 1'b1, 1'b0, 6'b00_01_10, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 F_lookup_i = 1'b1;
        @(negedge clk) chk("defer_0", tbl_we_o, 0);
        @(posedge clk);
        #1 tbl_rdata_i = 6'b11_00_00;
        @(negedge clk) chk("defer_1", tbl_we_o, 0);
        @(posedge clk);
        #1;
        @(negedge clk) chk("defer_2", tbl_we_o, 0);
        @(posedge clk);
        #1 F_lookup_i = 1'b0;
        @(negedge clk) chk("defer_wr", tbl_we_o, 1);
        @(posedge clk);
        #1 chk("defer_drain", exp_q.size(), 0);
        chk("ghr_defer", ghr_o, ghr_m);

        F_lookup_i    = 1'b1;
        F_lookup_pc_i = 32'h0000_03F0;
        #1;
        chk("fetch_en_we", {tbl_en_o, tbl_we_o}, 2'b10);
        chk("fetch_lidx", tbl_lidx_o, 8'hFC);
        chk("fetch_gidx", tbl_gidx_o, 8'hFC ^ ghr_m);
        F_lookup_i = 1'b0;
        @(posedge clk);
        #1;

        // Reset in the middle of a deferred write drops it entirely.
        tbl_rdata_i = 6'b00_00_00;
        enq(32'h100, 1'b1, 1'b1, 1'b1, 6'b00_00_00, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 F_lookup_i = 1'b1;
        @(negedge clk) chk("rst_wr_hold", tbl_we_o, 0);
        rst_n      = 1'b0;
        F_lookup_i = 1'b0;
        #1;
        chk("midrst_ready", D_br_ready_o, 1);
        chk("midrst_ghr", ghr_o, 0);
        chk("midrst_en", tbl_en_o, 0);
        ghr_m = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        n_en = 0;
        repeat (6) begin
            @(negedge clk);
            if (tbl_en_o) n_en++;
        end
        chk("post_rst_idle", n_en, 0);
        chk("exp_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
